// File: rtl/pipe_pkg.sv
// Shared definitions for the Y86-64 pipeline registers: field widths, bundle
// layouts and offsets, icode/stat encodings and the per-stage bubble patterns.
package pipe_pkg;

  localparam int STAT_W  = 4;
  localparam int ICODE_W = 4;
  localparam int REG_W   = 4;
  localparam int WORD_W  = 64;
  localparam int CC_W    = 3;

  localparam int D_W = 148;
  localparam int E_W = 220;
  localparam int M_W = 145;
  localparam int W_W = 144;

  // Bit offsets of the leading fields; each bundle is packed MSB-first.
  localparam int D_STAT_LSB  = 144;
  localparam int D_ICODE_LSB = 140;
  localparam int E_STAT_LSB  = 216;
  localparam int E_ICODE_LSB = 212;
  localparam int M_STAT_LSB  = 141;
  localparam int M_ICODE_LSB = 137;
  localparam int W_STAT_LSB  = 140;
  localparam int W_ICODE_LSB = 136;

  localparam logic [ICODE_W-1:0] ICODE_NOP    = 4'h1;
  localparam logic [ICODE_W-1:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] ICODE_OPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] ICODE_JXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICODE_RET    = 4'h9;
  localparam logic [ICODE_W-1:0] ICODE_POPQ   = 4'hB;

  localparam logic [STAT_W-1:0] STAT_AOK = 4'b1000;
  localparam logic [STAT_W-1:0] STAT_HLT = 4'b0100;
  localparam logic [STAT_W-1:0] STAT_ADR = 4'b0010;
  localparam logic [STAT_W-1:0] STAT_INS = 4'b0001;

  localparam logic [REG_W-1:0] REG_NONE = 4'hF;
  localparam logic [CC_W-1:0]  CC_RESET = 3'b100;

  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [3:0]         ifun;
    logic [REG_W-1:0]   rA;
    logic [REG_W-1:0]   rB;
    logic [WORD_W-1:0]  valC;
    logic [WORD_W-1:0]  valP;
  } d_t;

  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [3:0]         ifun;
    logic [WORD_W-1:0]  valC;
    logic [WORD_W-1:0]  valA;
    logic [WORD_W-1:0]  valB;
    logic [REG_W-1:0]   dstE;
    logic [REG_W-1:0]   dstM;
    logic [REG_W-1:0]   srcA;
    logic [REG_W-1:0]   srcB;
  } e_t;

  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic               Cnd;
    logic [WORD_W-1:0]  valE;
    logic [WORD_W-1:0]  valA;
    logic [REG_W-1:0]   dstE;
    logic [REG_W-1:0]   dstM;
  } m_t;

  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [WORD_W-1:0]  valE;
    logic [WORD_W-1:0]  valM;
    logic [REG_W-1:0]   dstE;
    logic [REG_W-1:0]   dstM;
  } w_t;

  localparam d_t D_BUBBLE = '{stat: STAT_AOK, icode: ICODE_NOP, ifun: 4'h0,
                              rA: REG_NONE, rB: REG_NONE, valC: '0, valP: '0};
  localparam e_t E_BUBBLE = '{stat: STAT_AOK, icode: ICODE_NOP, ifun: 4'h0,
                              valC: '0, valA: '0, valB: '0,
                              dstE: REG_NONE, dstM: REG_NONE,
                              srcA: REG_NONE, srcB: REG_NONE};
  localparam m_t M_BUBBLE = '{stat: STAT_AOK, icode: ICODE_NOP, Cnd: 1'b0,
                              valE: '0, valA: '0,
                              dstE: REG_NONE, dstM: REG_NONE};
  localparam w_t W_BUBBLE = '{stat: STAT_AOK, icode: ICODE_NOP,
                              valE: '0, valM: '0,
                              dstE: REG_NONE, dstM: REG_NONE};

endpackage

// File: rtl/pipe_reg.sv
// Width-parameterised pipeline register: stall holds, bubble injects
// bubble_val_i, otherwise loads d_i. Stall has priority over bubble.
module pipe_reg #(
  parameter int                 DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic [DATA_W-1:0] bubble_val_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    data_d = d_i;
    if (stall_i)       data_d = data_q;
    else if (bubble_i) data_d = bubble_val_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= RST_VAL;
    else     data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// F/D/E/M/W pipeline registers and condition codes driven by the hazard
// controller's stall/bubble/setcc commands. Optional PIPE_PERF_CNT_EN adds counters.
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter logic [2:0]  CC_RESET = pipe_pkg::CC_RESET
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [63:0]    f_pred_pc,
  input  logic [D_W-1:0] d_in,
  input  logic [E_W-1:0] e_in,
  input  logic [M_W-1:0] m_in,
  input  logic [W_W-1:0] w_in,
  input  logic [2:0]     cc_new,
  input  logic           F_stall,
  input  logic           D_stall,
  input  logic           D_bubble,
  input  logic           E_bubble,
  input  logic           M_bubble,
  input  logic           W_stall,
  input  logic           setcc,
  output logic [63:0]    F_predPC,
  output logic [D_W-1:0] D_q,
  output logic [E_W-1:0] E_q,
  output logic [M_W-1:0] M_q,
  output logic [W_W-1:0] W_q,
  output logic [2:0]     cc,
  output logic           ctrl_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_stalls,
  output logic [31:0]    perf_bubbles
`endif
);

  pipe_reg #(.DATA_W(64), .RST_VAL(PC_RESET)) u_f (
    .clk(clk), .rst(rst), .stall_i(F_stall), .bubble_i(1'b0),
    .bubble_val_i('0), .d_i(f_pred_pc), .q_o(F_predPC)
  );

  pipe_reg #(.DATA_W(D_W), .RST_VAL(D_BUBBLE)) u_d (
    .clk(clk), .rst(rst), .stall_i(D_stall), .bubble_i(D_bubble),
    .bubble_val_i(D_BUBBLE), .d_i(d_in), .q_o(D_q)
  );

  pipe_reg #(.DATA_W(E_W), .RST_VAL(E_BUBBLE)) u_e (
    .clk(clk), .rst(rst), .stall_i(1'b0), .bubble_i(E_bubble),
    .bubble_val_i(E_BUBBLE), .d_i(e_in), .q_o(E_q)
  );

  pipe_reg #(.DATA_W(M_W), .RST_VAL(M_BUBBLE)) u_m (
    .clk(clk), .rst(rst), .stall_i(1'b0), .bubble_i(M_bubble),
    .bubble_val_i(M_BUBBLE), .d_i(m_in), .q_o(M_q)
  );

  pipe_reg #(.DATA_W(W_W), .RST_VAL(W_BUBBLE)) u_w (
    .clk(clk), .rst(rst), .stall_i(W_stall), .bubble_i(1'b0),
    .bubble_val_i(W_BUBBLE), .d_i(w_in), .q_o(W_q)
  );

  logic [2:0] cc_d, cc_q;
  logic       err_d, err_q;

  // Only an OPq currently in E may update the flags.
  always_comb begin
    cc_d  = cc_q;
    if (setcc && (E_q[E_ICODE_LSB +: ICODE_W] == ICODE_OPQ)) cc_d = cc_new;
    err_d = err_q | (D_stall & D_bubble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q  <= CC_RESET;
      err_q <= 1'b0;
    end else begin
      cc_q  <= cc_d;
      err_q <= err_d;
    end
  end

  assign cc       = cc_q;
  assign ctrl_err = err_q;

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] cyc_q, stl_q, bub_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      stl_q <= '0;
      bub_q <= '0;
    end else begin
      cyc_q <= sat_inc(cyc_q, 1'b1);
      stl_q <= sat_inc(stl_q, D_stall);
      bub_q <= sat_inc(bub_q, E_bubble | D_bubble);
    end
  end

  assign perf_cycles  = cyc_q;
  assign perf_stalls  = stl_q;
  assign perf_bubbles = bub_q;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed, table-driven bench for pipe_stage_regs plus hand-written sequences
// for asynchronous reset, edge timing and reset during a stall.
module tb_pipe_stage_regs;

  logic           clk = 1'b0;
  logic           rst;
  logic [63:0]    f_pred_pc;
  logic [147:0]   d_in;
  logic [219:0]   e_in;
  logic [144:0]   m_in;
  logic [143:0]   w_in;
  logic [2:0]     cc_new;
  logic           F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, setcc;
  logic [63:0]    F_predPC;
  logic [147:0]   D_q;
  logic [219:0]   E_q;
  logic [144:0]   M_q;
  logic [143:0]   W_q;
  logic [2:0]     cc;
  logic           ctrl_err;

  int nvec = 0;
  int nbad = 0;

  pipe_stage_regs dut (
    .clk(clk), .rst(rst), .f_pred_pc(f_pred_pc),
    .d_in(d_in), .e_in(e_in), .m_in(m_in), .w_in(w_in), .cc_new(cc_new),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall), .setcc(setcc),
    .F_predPC(F_predPC), .D_q(D_q), .E_q(E_q), .M_q(M_q), .W_q(W_q),
    .cc(cc), .ctrl_err(ctrl_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [147:0] mk_d(logic [3:0] st, ic, fn, ra, rb,
                                        logic [63:0] vc, vp);
    return {st, ic, fn, ra, rb, vc, vp};
  endfunction

  function automatic logic [219:0] mk_e(logic [3:0] st, ic, fn,
                                        logic [63:0] vc, va, vb,
                                        logic [3:0] de, dm, sa, sb);
    return {st, ic, fn, vc, va, vb, de, dm, sa, sb};
  endfunction

  function automatic logic [144:0] mk_m(logic [3:0] st, ic, logic cnd,
                                        logic [63:0] ve, va, logic [3:0] de, dm);
    return {st, ic, cnd, ve, va, de, dm};
  endfunction

  function automatic logic [143:0] mk_w(logic [3:0] st, ic, logic [63:0] ve, vm,
                                        logic [3:0] de, dm);
    return {st, ic, ve, vm, de, dm};
  endfunction

  task automatic chk(input string nm, input logic [219:0] act, input logic [219:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] pc,
                         input logic [147:0] d, input logic [219:0] e,
                         input logic [144:0] m, input logic [143:0] w,
                         input logic [2:0] c, input logic err);
    chk({tag, ".pc"},  F_predPC, pc);
    chk({tag, ".D"},   D_q, d);
    chk({tag, ".E"},   E_q, e);
    chk({tag, ".M"},   M_q, m);
    chk({tag, ".W"},   W_q, w);
    chk({tag, ".cc"},  cc, c);
    chk({tag, ".err"}, ctrl_err, err);
  endtask

  typedef struct {
    logic [63:0]  pc;
    logic [147:0] d;
    logic [219:0] e;
    logic [144:0] m;
    logic [143:0] w;
    logic [2:0]   ccn;
    logic [6:0]   ctl;   // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,setcc}
    logic [63:0]  xpc;
    logic [147:0] xd;
    logic [219:0] xe;
    logic [144:0] xm;
    logic [143:0] xw;
    logic [2:0]   xcc;
    logic         xerr;
  } vec_t;

  vec_t tbl[10];

  logic [147:0] DB, D1, D2, D3;
  logic [219:0] EB, E1, E2, E3;
  logic [144:0] MB, M1, M2, M3;
  logic [143:0] WB, W1, W2, W3;

  task automatic drive(input vec_t v);
    f_pred_pc = v.pc;
    d_in      = v.d;
    e_in      = v.e;
    m_in      = v.m;
    w_in      = v.w;
    cc_new    = v.ccn;
    {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, setcc} = v.ctl;
  endtask

  initial begin
    DB = mk_d(4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    EB = mk_e(4'b1000, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    MB = mk_m(4'b1000, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
    WB = mk_w(4'b1000, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);

    D1 = mk_d(4'b1000, 4'h6, 4'h0, 4'h2, 4'h3, 64'h1234, 64'h0A);
    D2 = mk_d(4'b1000, 4'h5, 4'h0, 4'h4, 4'h5, 64'h8, 64'h14);
    D3 = mk_d(4'b0100, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h15);
    E1 = mk_e(4'b1000, 4'h6, 4'h1, 64'h0, 64'h11, 64'h22, 4'h3, 4'hF, 4'h2, 4'h3);
    E2 = mk_e(4'b1000, 4'h5, 4'h0, 64'h8, 64'h0, 64'h100, 4'hF, 4'h4, 4'hF, 4'h5);
    E3 = mk_e(4'b1000, 4'h6, 4'h2, 64'h0, 64'h5, 64'h6, 4'h7, 4'hF, 4'h8, 4'h7);
    M1 = mk_m(4'b1000, 4'h6, 1'b1, 64'hAA, 64'hBB, 4'h3, 4'hF);
    M2 = mk_m(4'b1000, 4'h5, 1'b0, 64'h108, 64'h0, 4'hF, 4'h4);
    M3 = mk_m(4'b0000, 4'h9, 1'b1, 64'hDEAD, 64'hBEEF, 4'h4, 4'hF);
    W1 = mk_w(4'b1000, 4'h6, 64'hAA, 64'h0, 4'h3, 4'hF);
    W2 = mk_w(4'b1000, 4'h5, 64'h108, 64'h77, 4'hF, 4'h4);
    W3 = mk_w(4'b0010, 4'hB, 64'h200, 64'h300, 4'h4, 4'h8);

    // pc, d, e, m, w, cc_new, ctl, expected pc, D, E, M, W, cc, err
    tbl[0] = '{64'h10, D1, E1, M1, W1, 3'b010, 7'b0000001, 64'h10, D1, E1, M1, W1, 3'b100, 1'b0};
    tbl[1] = '{64'h18, D2, E2, M2, W2, 3'b010, 7'b0000001, 64'h18, D2, E2, M2, W2, 3'b010, 1'b0};
    tbl[2] = '{64'h20, D3, E3, M3, W3, 3'b001, 7'b0000001, 64'h20, D3, E3, M3, W3, 3'b010, 1'b0};
    tbl[3] = '{64'h28, D1, E1, M1, W1, 3'b001, 7'b0000000, 64'h28, D1, E1, M1, W1, 3'b010, 1'b0};
    tbl[4] = '{64'h40, D2, E2, M2, W2, 3'b001, 7'b1101001, 64'h28, D1, EB, M2, W2, 3'b001, 1'b0};
    tbl[5] = '{64'h50, D3, E3, M3, W3, 3'b111, 7'b0011001, 64'h50, DB, EB, M3, W3, 3'b001, 1'b0};
    tbl[6] = '{64'h58, D2, E2, M1, W1, 3'b111, 7'b0000110, 64'h58, D2, E2, MB, W3, 3'b001, 1'b0};
    tbl[7] = '{64'h60, D3, E1, M1, W1, 3'b111, 7'b0110001, 64'h60, D2, E1, M1, W1, 3'b001, 1'b1};
    tbl[8] = '{64'h68, D3, E3, M3, W3, 3'b010, 7'b0000000, 64'h68, D3, E3, M3, W3, 3'b001, 1'b1};
    tbl[9] = '{64'h70, D1, E1, M1, W1, 3'b010, 7'b0000001, 64'h70, D1, E1, M1, W1, 3'b010, 1'b1};

    rst = 1'b0;
    f_pred_pc = '0; d_in = '0; e_in = '0; m_in = '0; w_in = '0; cc_new = '0;
    {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, setcc} = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1 chk_all("rst", 64'h0, DB, EB, MB, WB, 3'b100, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), tbl[i].xpc, tbl[i].xd, tbl[i].xe,
              tbl[i].xm, tbl[i].xw, tbl[i].xcc, tbl[i].xerr);
      @(negedge clk);
    end

    // A new d_in must not reach D_q before the next edge.
    {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, setcc} = '0;
    d_in = D2;
    #2 chk("pre_edge.D", D_q, D1);
    @(posedge clk);
    #1 chk("post_edge.D", D_q, D2);
    chk("err_sticky", ctrl_err, 1'b1);

    // Reset while F and D are stalled discards the held contents.
    @(negedge clk);
    F_stall = 1'b1; D_stall = 1'b1; f_pred_pc = 64'h99; d_in = D3;
    @(posedge clk);
    #1 chk("stall.pc", F_predPC, 64'h70);
    chk("stall.D", D_q, D2);
    #2 rst = 1'b1;
    #1 chk_all("rst_stall", 64'h0, DB, EB, MB, WB, 3'b100, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    F_stall = 1'b0; D_stall = 1'b0; f_pred_pc = 64'h80; d_in = D1;
    @(posedge clk);
    #1 chk("post_rst.pc", F_predPC, 64'h80);
    chk("post_rst.D", D_q, D1);
    chk("post_rst.err", ctrl_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Consumer end of the pipeline hazard-control interface for the 5-stage Y86-64 pipeline.
- Holds the F (predPC), D, E, M and W pipeline registers and the condition-code register.
- Each cycle, every register either loads, holds (stall) or injects a nop (bubble), as commanded by the stall/bubble/setcc signals from the pipeline controller.
- Also flags illegal control combinations.

Parameters:
- PC_RESET, 64'h0, predPC value after reset.
- CC_RESET, 3'b100, {ZF,SF,OF} after reset.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- f_pred_pc  in  64  next predicted PC from fetch
- d_in  in  148  D bundle {stat4,icode4,ifun4,rA4,rB4,valC64,valP64}
- e_in  in  220  E bundle {stat4,icode4,ifun4,valC64,valA64,valB64,dstE4,dstM4,srcA4,srcB4}
- m_in  in  145  M bundle {stat4,icode4,Cnd1,valE64,valA64,dstE4,dstM4}
- w_in  in  144  W bundle {stat4,icode4,valE64,valM64,dstE4,dstM4}
- cc_new  in  3  {ZF,SF,OF} computed by the ALU for the instruction in E
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  in  1 each  controller commands
- setcc  in  1  condition-code write permission from the controller
- F_predPC  out  64  registered predPC
- D_q, E_q, M_q, W_q  out  148/220/145/144  registered bundles, same layouts as the inputs
- cc  out  3  registered {ZF,SF,OF}
- ctrl_err  out  1  sticky illegal-control flag

Behaviour:
- All state updates on posedge clk; rst is asynchronous and active-high; rst overrides every other input.
- Reset values:
  - F_predPC=PC_RESET; cc=CC_RESET; ctrl_err=0.
  - D_q, E_q, M_q and W_q all hold their stage's bubble pattern.
- Bubble patterns:
  - Common fields: stat=4'b1000 (AOK), icode=4'h1 (nop), ifun=0, every register-ID field (rA/rB/dstE/dstM/srcA/srcB)=4'hF.
  - All data fields (valC/valP/valA/valB/valE/valM)=0; M Cnd=0.
- Per-stage update, in priority order:
  - F: F_stall ? hold : load f_pred_pc.
  - D: D_stall ? hold : D_bubble ? D bubble pattern : load d_in.
  - E: E_bubble ? E bubble pattern : load e_in.
  - M: M_bubble ? M bubble pattern : load m_in.
  - W: W_stall ? hold : load w_in.
- CC: load cc_new iff setcc=1 AND the current E_q.icode==4'h6 (OPq); otherwise hold.
- Latency: every input appears at its output exactly one cycle after the load edge; no combinational path from any input to any output.
- Illegal combination:
  - D_stall and D_bubble both 1: stall wins (D holds).
  - ctrl_err is set on that edge and stays set until rst.
- Simultaneous F_stall and D_stall (load/use hazard): F and D both hold; E is bubbled only if E_bubble=1 (behaviour follows the commands, no inference).
- A stalled stage holds bit-exact contents, including stat and data fields.
- Reset mid-stall: asserting rst while a stall is active discards the held contents; the first post-reset load follows the normal rules.
- Out-of-range or non-AOK stat values pass through unchanged; this block does no validation.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds three outputs, each 32 bits, all cleared by rst and saturating at 32'hFFFFFFFF:
  - perf_cycles: counts every cycle.
  - perf_stalls: counts cycles with D_stall=1.
  - perf_bubbles: counts cycles with E_bubble | D_bubble.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - Field widths and bundle bit offsets.
  - Icode constants (NOP=1, OPQ=6, JXX=7, RET=9, MRMOVQ=5, POPQ=B).
  - Stat encodings (AOK=1000, HLT=0100, ADR=0010, INS=0001).
  - REG_NONE=4'hF, the four bubble-pattern constants, CC_RESET.
- Sub-module pipe_reg: a width-parameterised register with stall/bubble/bubble-value inputs, instantiated once per stage (F and W with bubble tied 0).

Test Plan:
- Reset check: assert rst mid-cycle, no clock -> D_q/E_q/M_q/W_q.icode=4'h1 immediately, F_predPC=0, cc=3'b100, ctrl_err=0.
- Pass-through: free-running load with d_in.icode=4'h6, valC=64'h1234 -> D_q shows those values one edge later; nothing changes before the edge.
- Load/use: hold F_stall=D_stall=E_bubble=1 for 1 cycle, new f_pred_pc=64'h40, new d_in -> F_predPC and D_q unchanged; E_q.icode=1, E_q.dstM=4'hF.
- Mispredict: D_bubble=E_bubble=1 -> D_q and E_q show bubble patterns (stat=1000, rA=rB=4'hF); M_q loads m_in.
- CC gating:
  - E_q.icode=6, setcc=1, cc_new=3'b010 -> cc=010.
  - Same but setcc=0 -> cc holds.
  - E_q.icode=5, setcc=1 -> cc holds.
- Conflict: D_stall=D_bubble=1 -> D holds and ctrl_err=1 on that edge; ctrl_err stays 1 after the inputs return to 0 and clears only on rst.
